// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch stage feeding the IF/ID register
//
// Purpose:
//   Fetches one instruction at a time from instruction memory and holds it
//   for the IF/ID register until it is consumed (stall=0) or discarded by a
//   redirect. At most one memory request is ever outstanding; a request
//   orphaned by a redirect is drained in DROP before the next one is issued.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   stall              IF/ID is holding; presented instruction not consumed
//   redirect           one-cycle taken branch/jump pulse
//   redirect_pc        redirect target (low two bits ignored)
//   imem_req/addr      one-cycle fetch request and its address
//   imem_ack/rdata     one-cycle response strobe and instruction word
//   PC_out/inst_out    presented PC and instruction (bubble = 32'h0)
//   valid_out          PC_out/inst_out hold a real fetched instruction

module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_out,
   output logic [31:0] inst_out,
   output logic        valid_out
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DROP  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_buf_q, inst_buf_d;
   logic [31:0] redirect_target;

   // Targets are forced word aligned; the dropped low bits are intentionally unused.
   assign redirect_target = {redirect_pc[31:2], 2'b00};

   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         inst_buf_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_buf_q <= inst_buf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_buf_d = inst_buf_q;

      case (state_q)
         // One dead cycle after reset; a redirect here is ignored and any
         // late ack from a request abandoned by reset is simply not looked at.
         S_IDLE: begin
            state_d = S_ISSUE;
         end

         // A redirect suppresses the request this cycle and retries at the target.
         S_ISSUE: begin
            if (redirect) begin
               pc_d = redirect_target;
            end else begin
               state_d = S_WAIT;
            end
         end

         // Redirect beats ack: if the data arrives alongside the redirect it is
         // dropped here; otherwise the still-outstanding request is drained in DROP.
         S_WAIT: begin
            if (redirect) begin
               pc_d    = redirect_target;
               state_d = imem_ack ? S_ISSUE : S_DROP;
            end else if (imem_ack) begin
               inst_buf_d = imem_rdata;
               state_d    = S_HOLD;
            end
         end

         // Redirect beats stall; the buffered instruction is abandoned.
         S_HOLD: begin
            if (redirect) begin
               pc_d    = redirect_target;
               state_d = S_ISSUE;
            end else if (!stall) begin
               pc_d    = pc_q + 32'd4;
               state_d = S_ISSUE;
            end
         end

         // Waiting for the orphaned response; its data never reaches inst_buf.
         S_DROP: begin
            if (redirect) begin
               pc_d = redirect_target;
            end
            if (imem_ack) begin
               state_d = S_ISSUE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign imem_req  = (state_q == S_ISSUE) && !redirect;
   assign imem_addr = pc_q;
   assign valid_out = (state_q == S_HOLD);
   assign inst_out  = (state_q == S_HOLD) ? inst_buf_q : 32'h0;
   assign PC_out    = pc_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  downstream IF/ID register is holding; the presented instruction is not consumed this cycle.
REQ-005 redirect  input  1  one-cycle pulse; branch/jump taken, fetch restarts at redirect_pc.
REQ-006 redirect_pc  input  32  redirect target address.
REQ-007 imem_req  output  1  one-cycle fetch request to instruction memory.
REQ-008 imem_addr  output  32  fetch address, valid while imem_req=1.
REQ-009 imem_ack  input  1  one-cycle response strobe; arrives at least 1 cycle after imem_req.
REQ-010 imem_rdata  input  32  instruction word, valid while imem_ack=1.
REQ-011 PC_out  output  32  PC of presented instruction (feeds IF/ID PC_in).
REQ-012 inst_out  output  32  presented instruction (feeds IF/ID inst_in); 32'h0 bubble when invalid.
REQ-013 valid_out  output  1  PC_out/inst_out hold a real fetched instruction.

Function
REQ-014 The block SHALL hold a 32-bit pc_reg, a 32-bit inst_buf and a 3-bit state: IDLE, ISSUE, WAIT, HOLD, DROP; at most one memory request outstanding.
REQ-015 IDLE SHALL last exactly one cycle after reset release, then go to ISSUE; imem_req=0 in IDLE.
REQ-016 imem_req SHALL equal (state==ISSUE && !redirect); imem_addr SHALL equal pc_reg at all times.
REQ-017 ISSUE with imem_req=1 SHALL go to WAIT next cycle.
REQ-018 WAIT with imem_ack=1 and redirect=0 SHALL load inst_buf<=imem_rdata and go to HOLD; WAIT without ack SHALL stay in WAIT.
REQ-019 In HOLD: valid_out=1, inst_out=inst_buf, PC_out=pc_reg; all other states: valid_out=0, inst_out=32'h0, PC_out=pc_reg.
REQ-020 HOLD with stall=0 and redirect=0 SHALL set pc_reg<=pc_reg+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) and go to ISSUE; HOLD with stall=1 SHALL keep pc_reg, inst_buf and state unchanged.
REQ-021 Redirect SHALL have priority over stall and over ack in every non-IDLE state, and SHALL set pc_reg<={redirect_pc[31:2],2'b00}.
REQ-022 Redirect in ISSUE: no request issued that cycle; stay in ISSUE.
REQ-023 Redirect in HOLD: inst_buf discarded; go to ISSUE.
REQ-024 Redirect in WAIT without ack: go to DROP; with simultaneous ack: discard rdata, go to ISSUE.
REQ-025 DROP SHALL wait for imem_ack, discard rdata, go to ISSUE; redirect in DROP updates pc_reg and stays in DROP unless ack arrives the same cycle (then ISSUE).
REQ-026 Redirect in IDLE SHALL be ignored.
REQ-027 Minimum latency: imem_req to valid_out = ack latency + 1 cycle; steady-state, no stall, 1-cycle memory: one instruction per 3 cycles.
REQ-028 Throughput/ordering: instructions SHALL be presented in program order, none skipped or duplicated absent redirect.

Reset
REQ-029 While rst=1 (asynchronously): state=IDLE, pc_reg=RESET_PC, inst_buf=0, imem_req=0, valid_out=0, inst_out=0, PC_out=RESET_PC.
REQ-030 Reset asserted mid-WAIT/DROP SHALL abandon the outstanding request; a late imem_ack arriving in IDLE SHALL be ignored.

Verification
REQ-031 Reset release, memory 1-cycle ack returning 32'h0000_0013 -> req at addr 0 in cycle 2, valid_out=1 PC_out=0 inst_out=32'h13 in cycle 4, next req addr 4 in cycle 5.
REQ-032 stall=1 for 5 cycles while in HOLD -> PC_out, inst_out, valid_out frozen, no imem_req; release -> next req at PC_out+4.
REQ-033 redirect to 32'h0000_0102 while WAIT (3-cycle memory) -> state DROP, stale rdata never on inst_out, next imem_addr=32'h0000_0100.
REQ-034 redirect and imem_ack same cycle in WAIT -> rdata discarded, ISSUE next cycle at redirect target; redirect with stall=1 in HOLD -> redirect wins.
REQ-035 pc_reg=32'hFFFF_FFFC, consumed with stall=0 -> next imem_addr=32'h0000_0000.
REQ-036 rst asserted during WAIT, ack arrives during IDLE -> valid_out stays 0, first post-reset fetch at RESET_PC.
